// File: rtl/quad_adc_pkg.sv
// Shared types, widths and the sample packing helper for the quad ADC capture path.
package quad_adc_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam int unsigned SAMPLE_WIDTH = 14;
    localparam int unsigned LANE_WIDTH   = 16;
    localparam int unsigned PAD_WIDTH    = LANE_WIDTH - SAMPLE_WIDTH;
    localparam int unsigned WORD_WIDTH   = 4 * LANE_WIDTH;

    // Channel 1 lands in the low lane; each lane is zero-extended to 16 bits.
    function automatic logic [WORD_WIDTH-1:0] pack_samples(
        input logic [SAMPLE_WIDTH-1:0] ch1,
        input logic [SAMPLE_WIDTH-1:0] ch2,
        input logic [SAMPLE_WIDTH-1:0] ch3,
        input logic [SAMPLE_WIDTH-1:0] ch4
    );
        return {{PAD_WIDTH{1'b0}}, ch4, {PAD_WIDTH{1'b0}}, ch3,
                {PAD_WIDTH{1'b0}}, ch2, {PAD_WIDTH{1'b0}}, ch1};
    endfunction

endpackage

// File: rtl/adc_axis_out_reg.sv
// Single-entry AXI-Stream output register with load/drop arbitration and a
// saturating count of kept samples that found the register full.
module adc_axis_out_reg
    import quad_adc_pkg::*;
#(
    parameter int unsigned DROP_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load_req,
    input  logic [WORD_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  force_last,
    input  logic                  tready,
    output logic                  tvalid,
    output logic [WORD_WIDTH-1:0] tdata,
    output logic                  tlast,
    output logic                  loaded,
    output logic                  pending,
    output logic                  overrun,
    output logic [DROP_WIDTH-1:0] drop_count
);

    logic                  tvalid_q, tvalid_d;
    logic [WORD_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  overrun_q, overrun_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  handshake;
    logic                  drop;

    assign handshake = tvalid_q & tready;
    // A word leaving in this cycle frees the slot for a same-cycle load.
    assign loaded    = load_req & (~tvalid_q | tready);
    assign drop      = load_req & tvalid_q & ~tready;
    // Word still held after this cycle's edge.
    assign pending   = tvalid_q & ~tready;

    // Next-state for the held word and the drop statistics.
    always_comb begin
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        overrun_d = overrun_q;
        drop_d    = drop_q;
        if (loaded) begin
            tvalid_d = 1'b1;
            tdata_d  = load_data;
            tlast_d  = load_last;
        end else if (handshake) begin
            tvalid_d = 1'b0;
        end else if (force_last && pending) begin
            tlast_d = 1'b1;
        end
        if (clear) begin
            overrun_d = 1'b0;
            drop_d    = '0;
        end else if (drop) begin
            overrun_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + DROP_WIDTH'(1);
            end
        end
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            overrun_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign tvalid     = tvalid_q;
    assign tdata      = tdata_q;
    assign tlast      = tlast_q;
    assign overrun    = overrun_q;
    assign drop_count = drop_q;

endmodule

// File: rtl/quad_adc_capture_sequencer.sv
// Capture-run sequencer: decimates ADC sample sets, counts delivered words and
// drives the run FSM around a single-entry AXI-Stream output register.
module quad_adc_capture_sequencer
    import quad_adc_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 24,
    parameter int unsigned DECIM_WIDTH = 8,
    parameter int unsigned DROP_WIDTH  = 16
) (
    input  logic                    AXI_CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic                    ABORT,
    input  logic [COUNT_WIDTH-1:0]  SAMPLE_COUNT,
    input  logic [DECIM_WIDTH-1:0]  DECIMATION,
    input  logic                    ADC_DATA_VALID,
    input  logic [SAMPLE_WIDTH-1:0] ADC_CH_1_DATA,
    input  logic [SAMPLE_WIDTH-1:0] ADC_CH_2_DATA,
    input  logic [SAMPLE_WIDTH-1:0] ADC_CH_3_DATA,
    input  logic [SAMPLE_WIDTH-1:0] ADC_CH_4_DATA,
    output logic [WORD_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic                    M_AXIS_TLAST,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    OVERRUN,
    output logic [DROP_WIDTH-1:0]   DROP_COUNT
);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;
    logic [COUNT_WIDTH-1:0] words_inc;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [DECIM_WIDTH-1:0] phase_q, phase_d;
    logic                   aborted_q, aborted_d;
    logic                   done_q, done_d;
    logic                   clear;
    logic                   keep;
    logic                   load_req;
    logic                   load_last;
    logic                   force_last;
    logic                   loaded;
    logic                   pending;

    // words_q < count_q whenever a load can happen, so the increment never wraps.
    assign words_inc  = words_q + COUNT_WIDTH'(1);
    assign keep       = (state_q == StCapture) & ADC_DATA_VALID & (phase_q == '0);
    // ABORT beats a same-cycle kept sample; that sample is neither loaded nor dropped.
    assign load_req   = keep & ~ABORT;
    assign load_last  = (words_inc == count_q);
    assign force_last = (state_q == StCapture) & ABORT;

    // Run FSM, decimation phase and word counting.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        decim_d   = decim_q;
        phase_d   = phase_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        clear     = 1'b0;
        case (state_q)
            StIdle: begin
                if (START && (SAMPLE_COUNT != '0)) begin
                    state_d   = StCapture;
                    count_d   = SAMPLE_COUNT;
                    decim_d   = DECIMATION;
                    phase_d   = '0;
                    words_d   = '0;
                    aborted_d = 1'b0;
                    clear     = 1'b1;
                end
            end
            StCapture: begin
                if (ABORT) begin
                    aborted_d = pending;
                    state_d   = pending ? StFlush : StIdle;
                end else begin
                    if (ADC_DATA_VALID) begin
                        phase_d = (phase_q == decim_q) ? '0 : phase_q + DECIM_WIDTH'(1);
                    end
                    if (loaded) begin
                        words_d = words_inc;
                        if (load_last) begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                if (!pending) begin
                    state_d = StIdle;
                    done_d  = ~aborted_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state with synchronous reset.
    always_ff @(posedge AXI_CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            count_q   <= '0;
            words_q   <= '0;
            decim_q   <= '0;
            phase_q   <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            words_q   <= words_d;
            decim_q   <= decim_d;
            phase_q   <= phase_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    adc_axis_out_reg #(
        .DROP_WIDTH(DROP_WIDTH)
    ) u_out_reg (
        .clk       (AXI_CLK),
        .rst       (RESET),
        .clear     (clear),
        .load_req  (load_req),
        .load_data (pack_samples(ADC_CH_1_DATA, ADC_CH_2_DATA, ADC_CH_3_DATA, ADC_CH_4_DATA)),
        .load_last (load_last),
        .force_last(force_last),
        .tready    (M_AXIS_TREADY),
        .tvalid    (M_AXIS_TVALID),
        .tdata     (M_AXIS_TDATA),
        .tlast     (M_AXIS_TLAST),
        .loaded    (loaded),
        .pending   (pending),
        .overrun   (OVERRUN),
        .drop_count(DROP_COUNT)
    );

    assign BUSY = (state_q != StIdle);
    assign DONE = done_q;

endmodule

// File: doc/quad_adc_capture_sequencer.md
Name: quad_adc_capture_sequencer

Overview:
- Sequences one capture run of the quad ADC on the AXI clock side of the ADC clock-domain crossing.
- Consumes the crossing's single-cycle valid pulses and 4x14-bit sample sets, decimates them, and packs each kept set into one 64-bit word.
- Emits exactly SAMPLE_COUNT words on an AXI-Stream master toward the DMA, with TLAST on the final word.
- Software starts and aborts runs, and reads the BUSY, DONE and overrun status.

Parameters:
- COUNT_WIDTH, 24, width of the samples-per-run count.
- DECIM_WIDTH, 8, width of the decimation setting.
- DROP_WIDTH, 16, width of the saturating dropped-sample counter.

Ports:
- AXI_CLK  in  1  single clock for the whole block.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle pulse; begins a run; config is latched on this cycle.
- ABORT  in  1  single-cycle pulse; ends the run early.
- SAMPLE_COUNT  in  COUNT_WIDTH  number of words to deliver.
- DECIMATION  in  DECIM_WIDTH  keep 1 of every (DECIMATION+1) sample sets.
- ADC_DATA_VALID  in  1  single-cycle pulse from the CDC block.
- ADC_CH_1_DATA..ADC_CH_4_DATA  in  14 each  sample set; valid when ADC_DATA_VALID is high.
- M_AXIS_TDATA  out  64  packed word.
- M_AXIS_TVALID  out  1  word valid.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TLAST  out  1  marks the last word of a run.
- BUSY  out  1  high in CAPTURE and FLUSH.
- DONE  out  1  one-cycle pulse when a run completes normally.
- OVERRUN  out  1  sticky; at least one kept sample was dropped this run.
- DROP_COUNT  out  DROP_WIDTH  dropped kept samples this run; saturates at all-ones.

Behaviour:
- Reset:
  - State is IDLE.
  - All outputs are 0.
  - Internal counters and latched config are 0.
- States:
  - IDLE. START with SAMPLE_COUNT != 0 latches SAMPLE_COUNT and DECIMATION, clears OVERRUN and DROP_COUNT, loads the decimation phase so the next valid set is kept, and goes to CAPTURE. START with SAMPLE_COUNT == 0 is ignored.
  - CAPTURE. Each ADC_DATA_VALID advances the decimation phase. A kept set is loaded into the output register. After the SAMPLE_COUNT-th word is loaded, go to FLUSH.
  - FLUSH. Hold until the output register is empty (no TVALID, or a TVALID&TREADY handshake). On empty, go to IDLE and pulse DONE on that same transition.
- START is ignored in CAPTURE and FLUSH.
- Packing:
  - TDATA[15:0] = {2'b00, CH_1}.
  - TDATA[31:16] = {2'b00, CH_2}.
  - TDATA[47:32] = {2'b00, CH_3}.
  - TDATA[63:48] = {2'b00, CH_4}.
- Latency: a kept ADC_DATA_VALID in cycle t gives TVALID=1 in cycle t+1.
- Output register is single-entry. TVALID stays high with TDATA/TLAST stable until the handshake.
- Load rules for a kept sample:
  - Register empty: load it.
  - Handshake completing in the same cycle: load it, no drop.
  - Register full with TREADY low: drop it. Set OVERRUN and increment DROP_COUNT (saturating).
  - Dropped samples do not count toward SAMPLE_COUNT. A run therefore always delivers exactly SAMPLE_COUNT words.
- TLAST is 1 only on the word whose load makes the delivered count equal SAMPLE_COUNT.
- Decimation:
  - Phase counter runs 0..DECIMATION. A set is kept when phase == 0; phase wraps to 0 after DECIMATION.
  - DECIMATION = 0 keeps every set.
  - Phase advances on every ADC_DATA_VALID, including sets that are then dropped.
- Word counter is COUNT_WIDTH wide. SAMPLE_COUNT = all-ones is legal and must not wrap early.
- ABORT:
  - In CAPTURE: no further samples are accepted. If a word is pending, force its TLAST to 1 and go to FLUSH. If none is pending, go straight to IDLE. No DONE pulse in either case.
  - ABORT and a kept sample in the same cycle: ABORT wins; the sample is discarded and not counted as a drop.
  - In FLUSH or IDLE: ABORT has no effect.
- ADC_DATA_VALID in IDLE or FLUSH is ignored.
- RESET mid-run: TVALID drops immediately and the state returns to IDLE. This is the only permitted mid-transfer TVALID deassert.
- OVERRUN and DROP_COUNT hold their values after the run until the next accepted START.

Decomposition:
- Shared package quad_adc_pkg holds:
  - state encoding constants (IDLE, CAPTURE, FLUSH);
  - the ADC sample width constant (14);
  - the packed lane width (16);
  - a function that packs 4 samples into a 64-bit word.
- One natural sub-module: adc_axis_out_reg, the single-entry output register with the load/drop/handshake logic and the drop counter.
- Decimation, word counting and the FSM stay in the top level.

Test Plan:
- SAMPLE_COUNT=4, DECIMATION=0, TREADY=1, valid every 10 cycles, CH1..4=0x0001/0x0002/0x3FFF/0x2000.
  - Expect 4 words, each 0x2000_3FFF_0002_0001.
  - TVALID one cycle after each valid; TLAST on word 4 only.
  - DONE pulses one cycle after the 4th handshake; OVERRUN=0.
- SAMPLE_COUNT=3, DECIMATION=2, CH1 = ramp 0..8.
  - Expect output CH1 lanes 0, 3, 6; TLAST on 6.
- SAMPLE_COUNT=5, TREADY held 0 for 25 cycles, valid every 4 cycles.
  - Exactly 5 words still delivered after TREADY returns.
  - DROP_COUNT equals the number of sets that arrived while the register was full; OVERRUN=1.
  - A kept sample arriving in the same cycle as a handshake is not dropped.
- SAMPLE_COUNT=100; ABORT after 2 words with word 3 pending and TREADY=0.
  - Word 3 is delivered with TLAST=1 once TREADY=1.
  - No DONE pulse; BUSY falls after that handshake; later valids are ignored.
- Boundary cases:
  - START with SAMPLE_COUNT=0: BUSY stays 0 and no output.
  - START during CAPTURE: ignored; run length unchanged.
  - RESET while TVALID=1: all outputs 0 next cycle.
  - DROP_COUNT saturates at 0xFFFF (forced case with DROP_WIDTH=4 saturating at 0xF).
